// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel synchroniser, saturating stability counter,
// registered clean level and one-cycle rise/fall pulses, with optional tick scaling.
module debounce_bank #(
    parameter int               NCH         = 4,
    parameter int               NBITS       = 20,
    parameter int               NDELAY      = 65000,
    parameter int               SYNC_STAGES = 2,
    parameter logic [NCH-1:0]   RESET_VAL   = {NCH{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [NCH-1:0]  noisy,
    output logic [NCH-1:0]  clean,
    output logic [NCH-1:0]  rise,
    output logic [NCH-1:0]  fall,
    output logic            changed
);

    localparam logic [NBITS-1:0] DONE_CNT = NBITS'(NDELAY);

    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("debounce_bank: SYNC_STAGES must be >= 1");
    end
    if ((NDELAY < 1) || (NDELAY > ((2 ** NBITS) - 1))) begin : g_bad_delay
        $error("debounce_bank: NDELAY must lie in 1 .. 2**NBITS-1");
    end

    logic [NCH-1:0]   sync_r [SYNC_STAGES];
    logic [NCH-1:0]   sync_s;
    logic [NCH-1:0]   xnew_r;
    logic [NBITS-1:0] count_r [NCH];

    logic [NCH-1:0]   xnew_nxt_s;
    logic [NBITS-1:0] count_nxt_s [NCH];
    logic [NCH-1:0]   clean_nxt_s;
    logic [NCH-1:0]   rise_nxt_s;
    logic [NCH-1:0]   fall_nxt_s;
    logic             changed_nxt_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain bringing the raw pins into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= noisy;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Per-channel next state: a mismatch restarts the window; a full window commits the level.
    always_comb begin
        xnew_nxt_s  = xnew_r;
        clean_nxt_s = clean;
        rise_nxt_s  = {NCH{1'b0}};
        fall_nxt_s  = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            count_nxt_s[i] = count_r[i];
            if (sync_s[i] != xnew_r[i]) begin
                xnew_nxt_s[i]  = sync_s[i];
                count_nxt_s[i] = {NBITS{1'b0}};
            end else if (count_r[i] == DONE_CNT) begin
                // Commit is deliberately not tick-gated; the counter simply saturates here.
                clean_nxt_s[i] = xnew_r[i];
                rise_nxt_s[i]  = xnew_r[i] & ~clean[i];
                fall_nxt_s[i]  = ~xnew_r[i] & clean[i];
            end else if (tick) begin
                count_nxt_s[i] = count_r[i] + NBITS'(1);
            end else begin
                count_nxt_s[i] = count_r[i];
            end
        end
        changed_nxt_s = |(rise_nxt_s | fall_nxt_s);
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xnew_r  <= RESET_VAL;
            clean   <= RESET_VAL;
            rise    <= {NCH{1'b0}};
            fall    <= {NCH{1'b0}};
            changed <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                count_r[i] <= {NBITS{1'b0}};
            end
        end else begin
            xnew_r  <= xnew_nxt_s;
            clean   <= clean_nxt_s;
            rise    <= rise_nxt_s;
            fall    <= fall_nxt_s;
            changed <= changed_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                count_r[i] <= count_nxt_s[i];
            end
        end
    end

endmodule
